// File: rtl/k12a_mem_arbiter_pkg.sv
// Shared types for the k12a memory arbiter: memory mode, arbiter FSM states and owner tags.
package k12a_mem_arbiter_pkg;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_WR_HOLD,
    ST_DONE
  } arb_state_t;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DBG = 1'b1
  } arb_owner_t;

  localparam int WAIT_CNT_W = 4;

  function automatic logic [WAIT_CNT_W-1:0] sat_inc(input logic [WAIT_CNT_W-1:0] value,
                                                    input logic [WAIT_CNT_W-1:0] limit);
    return (value >= limit) ? limit : value + 1'b1;
  endfunction

endpackage

// File: rtl/k12a_mem_arbiter_strobe_gen.sv
// Write strobe generator: holds the strobe high for STROBE_CYCLES cycles after a start pulse.
module k12a_write_strobe_gen #(
  parameter int STROBE_CYCLES = 1
) (
  input  logic sys_clock,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic last
);

  logic       strobe;
  logic [1:0] cnt;

  // Strobe rises on the edge that leaves setup; cnt marks how many strobe cycles have elapsed.
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      strobe <= 1'b0;
      cnt    <= 2'd0;
    end else if (start) begin
      strobe <= 1'b1;
      cnt    <= 2'd0;
    end else if (strobe) begin
      if (cnt == 2'(STROBE_CYCLES - 1)) begin
        strobe <= 1'b0;
      end else begin
        cnt <= cnt + 2'd1;
      end
    end
  end

  assign busy = strobe;
  assign last = strobe && (cnt == 2'(STROBE_CYCLES - 1));

endmodule

// File: rtl/k12a_mem_arbiter.sv
// Two-master arbiter for the k12a memory port: CPU has priority, debug master is starvation-bounded.
module k12a_mem_arbiter
  import k12a_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_WAIT      = 4,
  parameter int STROBE_CYCLES = 1
) (
  input  logic                  sys_clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_done,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_done,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  mem_enable,
  output mem_mode_t             mem_mode,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_write_strobe
);

  arb_state_t            state;
  arb_owner_t            owner;
  logic [WAIT_CNT_W-1:0] wait_cnt;

  logic                  dbg_win;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  strobe_start;
  logic                  strobe_last;

  assign dbg_win   = dbg_req && (!cpu_req || (wait_cnt == WAIT_CNT_W'(MAX_WAIT)));
  assign sel_we    = dbg_win ? dbg_we    : cpu_we;
  assign sel_addr  = dbg_win ? dbg_addr  : cpu_addr;
  assign sel_wdata = dbg_win ? dbg_wdata : cpu_wdata;

  assign cpu_stall    = cpu_req && !cpu_gnt;
  assign strobe_start = (state == ST_WR_SETUP);

  k12a_write_strobe_gen #(
    .STROBE_CYCLES(STROBE_CYCLES)
  ) u_strobe_gen (
    .sys_clock(sys_clock),
    .reset    (reset),
    .start    (strobe_start),
    .busy     (mem_write_strobe),
    .last     (strobe_last)
  );

  // Access sequencer; request fields are captured only when a grant is issued from IDLE.
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= OWNER_CPU;
      wait_cnt   <= '0;
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      cpu_done   <= 1'b0;
      dbg_done   <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
      mem_enable <= 1'b0;
      mem_mode   <= MEM_READ;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      cpu_done <= 1'b0;
      dbg_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu_req || dbg_req) begin
            if (dbg_win) begin
              owner    <= OWNER_DBG;
              dbg_gnt  <= 1'b1;
              wait_cnt <= '0;
            end else begin
              owner    <= OWNER_CPU;
              cpu_gnt  <= 1'b1;
              wait_cnt <= dbg_req ? sat_inc(wait_cnt, WAIT_CNT_W'(MAX_WAIT)) : '0;
            end
            mem_enable <= 1'b1;
            mem_addr   <= sel_addr;
            if (sel_we) begin
              mem_mode  <= MEM_WRITE;
              mem_wdata <= sel_wdata;
              state     <= ST_WR_SETUP;
            end else begin
              mem_mode <= MEM_READ;
              state    <= ST_READ;
            end
          end else begin
            wait_cnt <= '0;
          end
        end
        ST_READ: begin
          if (owner == OWNER_DBG) begin
            dbg_rdata <= mem_rdata;
            dbg_done  <= 1'b1;
          end else begin
            cpu_rdata <= mem_rdata;
            cpu_done  <= 1'b1;
          end
          mem_enable <= 1'b0;
          state      <= ST_DONE;
        end
        ST_WR_SETUP: begin
          state <= ST_WR_STROBE;
        end
        ST_WR_STROBE: begin
          if (strobe_last) begin
            state <= ST_WR_HOLD;
          end
        end
        ST_WR_HOLD: begin
          dbg_done   <= (owner == OWNER_DBG);
          cpu_done   <= (owner == OWNER_CPU);
          mem_enable <= 1'b0;
          mem_mode   <= MEM_READ;
          mem_wdata  <= '0;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          cpu_gnt <= 1'b0;
          dbg_gnt <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
